// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// control-bundle layout and the per-hazard control-bundle builder.
package pipe_ctrl_pkg;

  localparam int REG_W_DEF = 4;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    HALT     = ST_HALT
  } state_t;

  localparam int CTL_PC_EN        = 0;
  localparam int CTL_IF_ID_EN     = 1;
  localparam int CTL_IF_ID_FLUSH  = 2;
  localparam int CTL_ID_EX_EN     = 3;
  localparam int CTL_ID_EX_BUBBLE = 4;
  localparam int CTL_EX_MEM_EN    = 5;
  localparam int CTL_W            = 6;

  typedef logic [CTL_W-1:0] ctl_t;

  // Control bundle for a pipeline that is free to move; a taken branch wins
  // over load-use because the ID instruction is then on the wrong path.
  function automatic ctl_t hazard_ctl(input logic branch, input logic load_use);
    ctl_t c;
    c = '1;
    if (!branch) begin
      c[CTL_IF_ID_FLUSH] = 1'b0;
      if (load_use) begin
        c[CTL_PC_EN]    = 1'b0;
        c[CTL_IF_ID_EN] = 1'b0;
      end else begin
        c[CTL_ID_EX_BUBBLE] = 1'b0;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are combinational
// (zero-cycle) from inputs and state, with a memory-wait watchdog and perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_bubble,
  output logic             ex_mem_enable,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              timeout_nxt;
  logic              load_use, mem_stall;
  ctl_t              ctl;

  assign load_use  = ex_load & ((id_use_rn & (id_rn == ex_rd)) |
                                (id_use_rm & (id_rm == ex_rd)));
  assign mem_stall = mem_req & ~mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  // ctl defaults to all-zero, which is the freeze bundle.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    timeout_nxt = mem_timeout;
    ctl         = '0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else begin
          ctl = hazard_ctl(ex_branch_taken, load_use);
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          if (wait_cnt == WAIT_W'(WAIT_MAX)) begin
            state_nxt   = HALT;
            timeout_nxt = 1'b1;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end else begin
          // Hazards that arrived during the wait are resolved on the release cycle.
          ctl       = hazard_ctl(ex_branch_taken, load_use);
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
    if (reset) begin
      ctl = '0;
    end
  end

  assign pc_enable     = ctl[CTL_PC_EN];
  assign if_id_enable  = ctl[CTL_IF_ID_EN];
  assign if_id_flush   = ctl[CTL_IF_ID_FLUSH];
  assign id_ex_enable  = ctl[CTL_ID_EX_EN];
  assign id_ex_bubble  = ctl[CTL_ID_EX_BUBBLE];
  assign ex_mem_enable = ctl[CTL_EX_MEM_EN];

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~ctl[CTL_PC_EN]),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctl[CTL_IF_ID_FLUSH]),
    .count (flush_count)
  );

endmodule
